// File: rtl/qsfp_hpd_monitor.sv
// Per-channel QSFP presence to HDMI hot-plug detect: debounces MODPRSL, holds hpd low
// for a minimum interval after every drop, and emits plug/unplug event pulses.
module qsfp_hpd_monitor #(
  parameter int CHANNEL_COUNT   = 2,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int MIN_LOW_CYCLES  = 20_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     input_valid,
  input  logic [CHANNEL_COUNT-1:0] modprsl_n,
  input  logic [CHANNEL_COUNT-1:0] force_replug,
  output logic [CHANNEL_COUNT-1:0] hpd,
  output logic [CHANNEL_COUNT-1:0] plug_pulse,
  output logic [CHANNEL_COUNT-1:0] unplug_pulse
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > MIN_LOW_CYCLES) ? DEBOUNCE_CYCLES : MIN_LOW_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(MIN_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ABSENT,
    DEBOUNCE_IN,
    PRESENT,
    DEBOUNCE_OUT,
    HOLD_LOW
  } state_t;

  logic [CHANNEL_COUNT-1:0] up;

  for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             present;

    assign present = ~modprsl_n[i];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state <= ABSENT;
        cnt   <= '0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
      end
    end

    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
        ABSENT: begin
          if (input_valid && present) state_next = DEBOUNCE_IN;
        end
        DEBOUNCE_IN: begin
          if (input_valid) begin
            if (!present)             state_next = ABSENT;
            else if (cnt == DEB_LAST) state_next = PRESENT;
            else                      cnt_next   = cnt + CNT_ONE;
          end
        end
        PRESENT: begin
          if (force_replug[i])                state_next = HOLD_LOW;
          else if (input_valid && !present)   state_next = DEBOUNCE_OUT;
        end
        DEBOUNCE_OUT: begin
          // A forced re-plug wins even while the expander data is stale
          if (force_replug[i]) state_next = HOLD_LOW;
          else if (input_valid) begin
            if (present)              state_next = PRESENT;
            else if (cnt == DEB_LAST) state_next = HOLD_LOW;
            else                      cnt_next   = cnt + CNT_ONE;
          end
        end
        HOLD_LOW: begin
          if (cnt == LOW_LAST) state_next = ABSENT;
          else                 cnt_next   = cnt + CNT_ONE;
        end
        default: state_next = ABSENT;
      endcase
      if (state_next != state) cnt_next = '0;
    end

    always_comb begin
      up[i] = (state == PRESENT) || (state == DEBOUNCE_OUT);
    end
  end

  // Output register stage: pulses are edges of the registered hpd
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hpd          <= '0;
      plug_pulse   <= '0;
      unplug_pulse <= '0;
    end else begin
      hpd          <= up;
      plug_pulse   <= up & ~hpd;
      unplug_pulse <= ~up & hpd;
    end
  end

endmodule

// File: tb/tb_qsfp_hpd_monitor.sv
// Bench for qsfp_hpd_monitor: directed scenarios followed by random traffic, all
// outputs compared every cycle against a run-length reference model.
module tb_qsfp_hpd_monitor;

  localparam int N = 2;
  localparam int D = 4;
  localparam int M = 8;

  logic         clock;
  logic         reset;
  logic         input_valid;
  logic [N-1:0] modprsl_n;
  logic [N-1:0] force_replug;
  logic [N-1:0] hpd;
  logic [N-1:0] plug_pulse;
  logic [N-1:0] unplug_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model: accepted level, length of the current disagreeing run, hold-low countdown
  bit           up   [N];
  int           pend [N];
  int           blk  [N];
  logic [N-1:0] m_hpd;
  logic [N-1:0] m_plug;
  logic [N-1:0] m_unplug;

  qsfp_hpd_monitor #(
    .CHANNEL_COUNT  (N),
    .DEBOUNCE_CYCLES(D),
    .MIN_LOW_CYCLES (M)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .input_valid (input_valid),
    .modprsl_n   (modprsl_n),
    .force_replug(force_replug),
    .hpd         (hpd),
    .plug_pulse  (plug_pulse),
    .unplug_pulse(unplug_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      up[i] = 1'b0; pend[i] = 0; blk[i] = 0;
    end
    m_hpd = '0; m_plug = '0; m_unplug = '0;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < N; i++) begin
      m_plug[i]   = up[i] & ~m_hpd[i];
      m_unplug[i] = ~up[i] & m_hpd[i];
      m_hpd[i]    = up[i];
      if (blk[i] > 0) begin
        blk[i]--;
      end else if (up[i] && force_replug[i]) begin
        up[i] = 1'b0; pend[i] = 0; blk[i] = M;
      end else if (input_valid) begin
        if ((!modprsl_n[i]) != up[i]) pend[i]++;
        else pend[i] = 0;
        // A new level is accepted after D+1 consecutive valid samples
        if (pend[i] == D + 1) begin
          up[i] = !up[i]; pend[i] = 0;
          if (!up[i]) blk[i] = M;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    if (!reset) model_reset();
    else model_step();
    #1;
    chk("hpd", 32'(hpd), 32'(m_hpd));
    chk("plug_pulse", 32'(plug_pulse), 32'(m_plug));
    chk("unplug_pulse", 32'(unplug_pulse), 32'(m_unplug));
    chk("pulse_overlap", 32'(plug_pulse & unplug_pulse), 32'd0);
  endtask

  task automatic pulse_reset();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_hpd", 32'(hpd), 32'd0);
    chk("async_rst_unplug", 32'(unplug_pulse), 32'd0);
    chk("async_rst_plug", 32'(plug_pulse), 32'd0);
    tick();
    #3;
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    input_valid  = 1'b1;
    modprsl_n    = 2'b11;
    force_replug = 2'b00;
    model_reset();

    // Reset, then idle with no modules
    tick();
    tick();
    #3 reset = 1'b1;
    for (int k = 0; k < 50; k++) tick();
    chk("idle_hpd", 32'(hpd), 32'd0);

    // Ch0 plug: hpd rises 6 cycles after the presence change
    modprsl_n[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) chk("plug_wait_hpd0", 32'(hpd[0]), 32'd0);
    end
    chk("plug_hpd0", 32'(hpd[0]), 32'd1);
    chk("plug_pulse0", 32'(plug_pulse[0]), 32'd1);
    chk("plug_hpd1", 32'(hpd[1]), 32'd0);
    tick();
    chk("plug_pulse0_once", 32'(plug_pulse[0]), 32'd0);

    // 3-cycle glitch while present, then while absent on ch1
    modprsl_n[0] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    modprsl_n[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("glitch_hpd0", 32'(hpd[0]), 32'd1);
      chk("glitch_unplug0", 32'(unplug_pulse[0]), 32'd0);
    end
    modprsl_n[1] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    modprsl_n[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("glitch_hpd1", 32'(hpd[1]), 32'd0);
    end

    // Forced re-plug with the module held present
    force_replug[0] = 1'b1;
    tick();
    force_replug[0] = 1'b0;
    chk("force_hpd0_t1", 32'(hpd[0]), 32'd1);
    for (int k = 2; k <= 15; k++) begin
      tick();
      if (k == 2) chk("force_unplug0", 32'(unplug_pulse[0]), 32'd1);
      if (k < 15) chk("force_low_hpd0", 32'(hpd[0]), 32'd0);
    end
    chk("force_rehpd0", 32'(hpd[0]), 32'd1);
    chk("force_replug0", 32'(plug_pulse[0]), 32'd1);

    // Ch1 debounce frozen by input_valid=0 after two counts
    modprsl_n[1] = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    input_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("frozen_hpd1", 32'(hpd[1]), 32'd0);
    end
    input_valid = 1'b1;
    tick();
    tick();
    chk("resume_hpd1_wait", 32'(hpd[1]), 32'd0);
    tick();
    chk("resume_hpd1", 32'(hpd[1]), 32'd1);
    chk("resume_plug1", 32'(plug_pulse[1]), 32'd1);
    tick();

    // Asynchronous reset with both channels up
    chk("pre_reset_hpd", 32'(hpd), 32'd3);
    pulse_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("post_reset_unplug", 32'(unplug_pulse), 32'd0);
      if (k < 6) chk("post_reset_wait", 32'(hpd), 32'd0);
    end
    chk("post_reset_hpd", 32'(hpd), 32'd3);
    chk("post_reset_plug", 32'(plug_pulse), 32'd3);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      input_valid = ($urandom_range(7) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(9) == 0) modprsl_n[i] = ~modprsl_n[i];
        force_replug[i] = ($urandom_range(39) == 0);
      end
      if ($urandom_range(799) == 0) pulse_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
